sfx_scheduler: RTL



---
 rtl/sfx_scheduler.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/sfx_scheduler.sv
// Sound-effect scheduler: latches four effect requests, grants by fixed priority, sequences note lists.
// Build option: define SFX_PREEMPT_EN to let a higher-priority request abort the running effect.
module sfx_scheduler #(
   parameter int          NOTE_CYC = 100_000_000,
   parameter int          GAP_CYC  = 5_000_000,
   parameter int          CNT_W    = 28,
   parameter logic [2:0]  VOLUME   = 3'd4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic [3:0]  req,
   output logic [21:0] note_div,
   output logic [2:0]  volume,
   output logic        busy,
   output logic [1:0]  active_id,
   output logic        done
);

   typedef enum logic [1:0] {S_IDLE, S_PLAY, S_GAP} state_t;

   localparam logic [21:0]      MUTE      = 22'h3FFFFF;
   localparam logic [CNT_W-1:0] NOTE_LAST = CNT_W'(NOTE_CYC - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = (GAP_CYC > 0) ? CNT_W'(GAP_CYC - 1) : '0;

   function automatic logic [21:0] note_lookup(input logic [1:0] id, input logic [1:0] idx);
      logic [21:0] nd;
      nd = MUTE;
      case (id)
         2'd0: nd = 22'd56_818;
         2'd1: nd = 22'd113_636;
         2'd2: case (idx)
                  2'd0:    nd = 22'd170_068;
                  2'd1:    nd = 22'd143_266;
                  default: nd = 22'd113_636;
               endcase
         default: case (idx)
                  2'd0:    nd = 22'd190_840;
                  2'd1:    nd = 22'd151_515;
                  default: nd = 22'd127_551;
               endcase
      endcase
      return nd;
   endfunction

   // Index of the final note in each effect's list.
   function automatic logic [1:0] last_idx(input logic [1:0] id);
      return id[1] ? 2'd2 : 2'd0;
   endfunction

   function automatic logic [1:0] first_set(input logic [3:0] v);
      logic [1:0] id;
      if (v[0])      id = 2'd0;
      else if (v[1]) id = 2'd1;
      else if (v[2]) id = 2'd2;
      else           id = 2'd3;
      return id;
   endfunction

`ifdef SFX_PREEMPT_EN
   function automatic logic [3:0] higher_mask(input logic [1:0] id);
      logic [3:0] m;
      case (id)
         2'd0:    m = 4'b0000;
         2'd1:    m = 4'b0001;
         2'd2:    m = 4'b0011;
         default: m = 4'b0111;
      endcase
      return m;
   endfunction
`endif

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       idx_q, idx_d;
   logic [3:0]       pend_q, pend_d;
   logic [21:0]      note_div_q, note_div_d;
   logic [2:0]       volume_q, volume_d;
   logic             busy_q, busy_d;
   logic [1:0]       active_id_q, active_id_d;
   logic             done_q, done_d;
   logic             grant, preempt;
   logic [1:0]       grant_id;
   logic [3:0]       grant_clr;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      idx_d       = idx_q;
      pend_d      = pend_q;
      note_div_d  = note_div_q;
      volume_d    = volume_q;
      busy_d      = busy_q;
      active_id_d = active_id_q;
      done_d      = 1'b0;
      grant       = 1'b0;
      grant_id    = first_set(pend_q);
      grant_clr   = 4'b0000;
`ifdef SFX_PREEMPT_EN
      preempt     = |(pend_q & higher_mask(active_id_q));
`else
      preempt     = 1'b0;
`endif

      if (!enable) begin
         // Abort and flush: nothing survives a disable, and no done pulse is produced.
         state_d    = S_IDLE;
         cnt_d      = '0;
         idx_d      = 2'd0;
         pend_d     = 4'b0000;
         note_div_d = MUTE;
         volume_d   = 3'd0;
         busy_d     = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (pend_q != 4'b0000) grant = 1'b1;
            end
            S_PLAY: begin
               if (preempt) begin
                  grant = 1'b1;
               end else if (cnt_q == NOTE_LAST) begin
                  cnt_d = '0;
                  if (idx_q != last_idx(active_id_q)) begin
                     idx_d      = idx_q + 2'd1;
                     note_div_d = note_lookup(active_id_q, idx_q + 2'd1);
                  end else begin
                     idx_d      = 2'd0;
                     done_d     = 1'b1;
                     note_div_d = MUTE;
                     volume_d   = 3'd0;
                     if (GAP_CYC > 0) begin
                        state_d = S_GAP;
                     end else begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                     end
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            S_GAP: begin
               if (preempt) begin
                  grant = 1'b1;
               end else if (cnt_q == GAP_LAST) begin
                  state_d = S_IDLE;
                  cnt_d   = '0;
                  busy_d  = 1'b0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            default: state_d = S_IDLE;
         endcase

         if (grant) begin
            state_d     = S_PLAY;
            cnt_d       = '0;
            idx_d       = 2'd0;
            active_id_d = grant_id;
            note_div_d  = note_lookup(grant_id, 2'd0);
            volume_d    = VOLUME;
            busy_d      = 1'b1;
            done_d      = 1'b0;
            grant_clr   = 4'b0001 << grant_id;
         end

         // A request on the grant cycle re-arms its own bit, so it replays later.
         pend_d = (pend_q & ~grant_clr) | req;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         idx_q       <= 2'd0;
         pend_q      <= 4'b0000;
         note_div_q  <= MUTE;
         volume_q    <= 3'd0;
         busy_q      <= 1'b0;
         active_id_q <= 2'd0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         pend_q      <= pend_d;
         note_div_q  <= note_div_d;
         volume_q    <= volume_d;
         busy_q      <= busy_d;
         active_id_q <= active_id_d;
         done_q      <= done_d;
      end
   end

   assign note_div  = note_div_q;
   assign volume    = volume_q;
   assign busy      = busy_q;
   assign active_id = active_id_q;
   assign done      = done_q;

endmodule
